rgba_axis_to_dvp: RTL and testbench

RGBA_AXIS_TO_DVP -- requirements
Module: rgba_axis_to_dvp

---
 rtl/rgba_axis_to_dvp_pkg.sv | 38 +++
 rtl/dvp_pclk_gen.sv | 34 +++
 rtl/rgba_axis_to_dvp.sv | 184 ++++++++++++++++++
 tb/tb_rgba_axis_to_dvp.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgba_axis_to_dvp_pkg.sv
// Shared types and constants for the RGBA AXI-Stream to DVP bridge.
// Holds the FSM states, RGBA field positions and RGB565 packing helpers.
package rgba_axis_to_dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_LINE,
        ST_HBLANK,
        ST_VFP
    } state_t;

    // RGBA field positions inside tdata
    localparam int R_MSB = 31;
    localparam int G_MSB = 23;
    localparam int B_MSB = 15;
    localparam int A_MSB = 7;

    // RGB565 packing: high byte {R5,G3hi}, low byte {G3lo,B5}
    localparam int R5_W = 5;
    localparam int G_HI_W = 3;
    localparam int G_LO_W = 3;
    localparam int B5_W = 5;

    function automatic logic [7:0] rgb565_hi(input logic [31:0] px);
        return {px[R_MSB -: R5_W], px[G_MSB -: G_HI_W]};
    endfunction

    function automatic logic [7:0] rgb565_lo(input logic [31:0] px);
        return {px[G_MSB-G_HI_W -: G_LO_W], px[B_MSB -: B5_W]};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_pclk_gen.sv
// Free-running DVP pixel clock divider.
// fall_tick is high in the axi_clk cycle whose edge drives pclk low.
module dvp_pclk_gen #(
    parameter int PCLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pclk,
    output logic fall_tick
);

    localparam int HALF = PCLK_DIV / 2;
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;
    logic          at_half;

    assign at_half   = (cnt == CW'(HALF - 1));
    assign fall_tick = at_half && pclk;

    // Half-period counter; pclk toggles each time it wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            pclk <= 1'b0;
        end else if (at_half) begin
            cnt  <= '0;
            pclk <= ~pclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rgba_axis_to_dvp.sv
// RGBA AXI-Stream sink that replays frames as an RGB565 DVP stream.
// All DVP outputs change only on the edge that drives pclk low.
module rgba_axis_to_dvp
    import rgba_axis_to_dvp_pkg::*;
#(
    parameter int FRAME_WIDTH   = 8,
    parameter int FRAME_HEIGHT  = 4,
    parameter int PCLK_DIV      = 4,
    parameter int VSYNC_CYCLES  = 8,
    parameter int VBLANK_CYCLES = 8,
    parameter int HBLANK_CYCLES = 4
) (
    input  logic        axi_clk,
    input  logic        areset,
    input  logic        enable,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        dvp_pclk,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        frame_done,
    output logic        underrun,
    output logic        sync_err
);

    localparam int CW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int LW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int LINE_PERIODS = 2 * FRAME_WIDTH;
    localparam int PMAX = max_int(max_int(VSYNC_CYCLES, VBLANK_CYCLES),
                                  max_int(HBLANK_CYCLES, LINE_PERIODS));
    localparam int PW = (PMAX > 1) ? $clog2(PMAX) : 1;

    state_t          state_q, state_d;
    logic            pclk_fall;
    logic [PW-1:0]   pcnt_q, limit;
    logic            period_last;
    logic [LW-1:0]   line_q, in_line_q;
    logic [CW-1:0]   in_col_q;
    logic            in_done_q, hold_full_q;
    logic [15:0]     hold_q;
    logic [7:0]      lo_q;
    logic            in_frame, discard, accept;
    logic            col_last, line_last_in, bad_beat;
    logic            consume, frame_end;

    dvp_pclk_gen #(
        .PCLK_DIV(PCLK_DIV)
    ) u_pclk (
        .clk      (axi_clk),
        .rst      (areset),
        .pclk     (dvp_pclk),
        .fall_tick(pclk_fall)
    );

    assign in_frame = (state_q == ST_VSYNC) || (state_q == ST_VBP) ||
                      (state_q == ST_LINE)  || (state_q == ST_HBLANK);
    assign discard  = (state_q == ST_IDLE) && enable && !s_axis_tuser;
    assign s_axis_tready = !areset &&
                           (discard || (in_frame && !hold_full_q && !in_done_q));
    assign accept   = s_axis_tvalid && s_axis_tready;

    assign col_last     = (in_col_q == CW'(FRAME_WIDTH - 1));
    assign line_last_in = (in_line_q == LW'(FRAME_HEIGHT - 1));
    assign bad_beat     = (s_axis_tlast != col_last) ||
                          (s_axis_tuser && (in_col_q != '0 || in_line_q != '0));

    assign consume   = pclk_fall && (state_q == ST_LINE) && !pcnt_q[0];
    assign frame_end = period_last && (state_q == ST_VFP);

    // Next-state logic; non-idle states advance only on pclk fall
    always_comb begin
        state_d = state_q;
        limit   = '0;
        unique case (state_q)
            ST_VSYNC:       limit = PW'(VSYNC_CYCLES - 1);
            ST_VBP, ST_VFP: limit = PW'(VBLANK_CYCLES - 1);
            ST_LINE:        limit = PW'(LINE_PERIODS - 1);
            ST_HBLANK:      limit = PW'(HBLANK_CYCLES - 1);
            default:        limit = '0;
        endcase
        period_last = pclk_fall && (pcnt_q == limit);
        unique case (state_q)
            ST_IDLE:
                if (enable && s_axis_tvalid && s_axis_tuser) state_d = ST_VSYNC;
            ST_VSYNC:
                if (period_last) state_d = ST_VBP;
            ST_VBP:
                if (period_last) state_d = ST_LINE;
            ST_LINE:
                if (period_last) state_d = ST_HBLANK;
            ST_HBLANK:
                if (period_last)
                    state_d = (line_q == LW'(FRAME_HEIGHT - 1)) ? ST_VFP : ST_LINE;
            ST_VFP:
                if (period_last) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge axi_clk) begin
        if (areset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Period counter within a state, and output line counter
    always_ff @(posedge axi_clk) begin
        if (areset) begin
            pcnt_q <= '0;
            line_q <= '0;
        end else begin
            if (state_q == ST_IDLE) pcnt_q <= '0;
            else if (pclk_fall)     pcnt_q <= period_last ? '0 : pcnt_q + 1'b1;
            if (period_last && state_q == ST_HBLANK)
                line_q <= (line_q == LW'(FRAME_HEIGHT - 1)) ? '0 : line_q + 1'b1;
        end
    end

    // Input side: holding register, beat position tracking, sync errors
    always_ff @(posedge axi_clk) begin
        if (areset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            in_col_q    <= '0;
            in_line_q   <= '0;
            in_done_q   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            sync_err <= accept && ((state_q == ST_IDLE) || bad_beat);
            if (frame_end) begin
                hold_full_q <= 1'b0;
                in_col_q    <= '0;
                in_line_q   <= '0;
                in_done_q   <= 1'b0;
            end else if (accept && in_frame) begin
                hold_q      <= {rgb565_hi(s_axis_tdata), rgb565_lo(s_axis_tdata)};
                hold_full_q <= 1'b1;
                in_col_q    <= col_last ? '0 : in_col_q + 1'b1;
                if (col_last) begin
                    in_line_q <= line_last_in ? '0 : in_line_q + 1'b1;
                    if (line_last_in) in_done_q <= 1'b1;
                end
            end else if (consume) begin
                hold_full_q <= 1'b0;
            end
        end
    end

    // DVP outputs, updated on pclk fall; empty holding reg yields a black pixel
    always_ff @(posedge axi_clk) begin
        if (areset) begin
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= '0;
            lo_q       <= '0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (pclk_fall) begin
                dvp_vsync <= (state_q == ST_VSYNC);
                dvp_href  <= (state_q == ST_LINE);
                dvp_data  <= '0;
                if (consume) begin
                    if (hold_full_q) begin
                        dvp_data <= hold_q[15:8];
                        lo_q     <= hold_q[7:0];
                    end else begin
                        lo_q     <= '0;
                        underrun <= 1'b1;
                    end
                end else if (state_q == ST_LINE) begin
                    dvp_data <= lo_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgba_axis_to_dvp.sv
// Directed bench for rgba_axis_to_dvp with an 8x4 frame.
// A negedge monitor records DVP bytes, href/vsync widths and pulses.
module tb_rgba_axis_to_dvp;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int DIV = 4;
    localparam int VS  = 8;
    localparam int VB  = 8;
    localparam int HB  = 4;

    logic        axi_clk = 1'b0;
    logic        areset = 1'b1;
    logic        enable = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tready;
    logic        dvp_pclk, dvp_vsync, dvp_href;
    logic [7:0]  dvp_data;
    logic        frame_done, underrun, sync_err;

    int checks = 0;
    int errors = 0;
    int timeouts = 0;

    always #5 axi_clk = ~axi_clk;

    rgba_axis_to_dvp #(
        .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PCLK_DIV(DIV),
        .VSYNC_CYCLES(VS), .VBLANK_CYCLES(VB), .HBLANK_CYCLES(HB)
    ) dut (
        .axi_clk(axi_clk), .areset(areset), .enable(enable),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .dvp_pclk(dvp_pclk),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .frame_done(frame_done), .underrun(underrun), .sync_err(sync_err)
    );

    logic [7:0] bytes_q[$];
    int widths_q[$];
    int vsw_q[$];
    int lat_q[$];
    int href_rises = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int cur_w = 0;
    int vs_w = 0;
    longint cyc = 0;
    longint vs_rise_cyc = 0;
    bit want_lat = 0;
    logic pclk_prev = 1'b0;
    logic href_prev = 1'b0;
    logic vsync_prev = 1'b0;

    // Receiver model: sample on pclk rise, track pulses and widths
    always @(negedge axi_clk) begin
        cyc++;
        if (frame_done === 1'b1) fd_cnt++;
        if (sync_err === 1'b1) se_cnt++;
        if (dvp_pclk === 1'b1 && pclk_prev === 1'b0) begin
            if (dvp_href === 1'b1) begin
                bytes_q.push_back(dvp_data);
                cur_w++;
            end
            if (dvp_vsync === 1'b1) vs_w++;
        end
        if (dvp_href === 1'b1 && href_prev === 1'b0) begin
            href_rises++;
            if (want_lat) begin
                lat_q.push_back(int'(cyc - vs_rise_cyc));
                want_lat = 0;
            end
        end
        if (dvp_href === 1'b0 && href_prev === 1'b1) begin
            widths_q.push_back(cur_w);
            cur_w = 0;
        end
        if (dvp_vsync === 1'b1 && vsync_prev === 1'b0) begin
            vs_rise_cyc = cyc;
            want_lat = 1;
            vs_w = 0;
        end
        if (dvp_vsync === 1'b0 && vsync_prev === 1'b1) vsw_q.push_back(vs_w);
        pclk_prev  = dvp_pclk;
        href_prev  = dvp_href;
        vsync_prev = dvp_vsync;
    end

    int b0, w0, h0, f0, e0, l0, v0;

    task automatic snap();
        b0 = bytes_q.size();
        w0 = widths_q.size();
        h0 = href_rises;
        f0 = fd_cnt;
        e0 = se_cnt;
        l0 = lat_q.size();
        v0 = vsw_q.size();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge axi_clk);
        #1;
    endtask

    function automatic logic [31:0] pix(input int mode, input int col,
                                        input int line);
        logic [7:0] p, g, b;
        p = 8'(16 * col + line);
        g = 8'h5C + p;
        b = 8'hC3 ^ p;
        if (mode == 0) return {p, 24'h0};
        return {p, g, b, 8'hA5};
    endfunction

    function automatic logic [7:0] hi565(input logic [31:0] px);
        return {px[31:27], px[23:21]};
    endfunction

    function automatic logic [7:0] lo565(input logic [31:0] px);
        return {px[20:18], px[15:11]};
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic u,
                             input logic l);
        bit done;
        done = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge axi_clk);
            if (s_axis_tready === 1'b1) begin
                @(posedge axi_clk);
                #1;
                done = 1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!done) timeouts++;
    endtask

    task automatic send_frame(input int mode, input int n, input int stall_at,
                              input int no_last_at);
        int t0;
        t0 = timeouts;
        for (int i = 0; i < n && timeouts == t0; i++) begin
            if (i == stall_at) begin
                bit seen;
                seen = 0;
                for (int k = 0; k < 2000 && !seen; k++) begin
                    @(negedge axi_clk);
                    if (s_axis_tready === 1'b1) seen = 1;
                end
                if (!seen) timeouts++;
                tick(3 * DIV);
            end
            send_beat(pix(mode, i % W, i / W), i == 0,
                      (i % W == W - 1) && (i != no_last_at));
        end
    endtask

    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (fd_cnt == f0 && k < 4000) begin
            tick(1);
            k++;
        end
        check({tag, "_done_seen"}, fd_cnt != f0, 1);
        tick(40);
    endtask

    task automatic verify(input string tag, input int mode, input int zslot);
        int mism, first;
        logic [7:0] g, e, fg, fe;
        mism = 0;
        first = -1;
        fg = '0;
        fe = '0;
        for (int s = 0; s < W * H; s++) begin
            logic [31:0] px;
            int src;
            src = (zslot >= 0 && s > zslot) ? s - 1 : s;
            px = (s == zslot) ? 32'h0 : pix(mode, src % W, src / W);
            for (int b = 0; b < 2; b++) begin
                e = (b == 0) ? hi565(px) : lo565(px);
                g = (b0 + 2 * s + b < bytes_q.size()) ?
                    bytes_q[b0 + 2 * s + b] : 8'hxx;
                if (g !== e) begin
                    if (first < 0) begin
                        first = 2 * s + b;
                        fg = g;
                        fe = e;
                    end
                    mism++;
                end
            end
        end
        checks++;
        assert (mism == 0) else begin
            errors++;
            $error("FAIL %s_bytes %0d wrong, first idx %0d observed 0x%02h expected 0x%02h",
                   tag, mism, first, fg, fe);
        end
    endtask

    task automatic check_frame(input string tag, input int mode,
                               input int zslot);
        int n16;
        n16 = 0;
        for (int i = w0; i < widths_q.size(); i++)
            if (widths_q[i] == 2 * W) n16++;
        check({tag, "_byte_count"}, bytes_q.size() - b0, 2 * W * H);
        check({tag, "_href_pulses"}, href_rises - h0, H);
        check({tag, "_href_widths"}, n16, H);
        check({tag, "_frame_done"}, fd_cnt - f0, 1);
        verify(tag, mode, zslot);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pclk"}, dvp_pclk, 0);
        check({tag, "_vsync"}, dvp_vsync, 0);
        check({tag, "_href"}, dvp_href, 0);
        check({tag, "_data"}, dvp_data, 0);
        check({tag, "_tready"}, s_axis_tready, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_sync_err"}, sync_err, 0);
        check({tag, "_underrun"}, underrun, 0);
    endtask

    initial begin
        int k;

        // reset state
        tick(3);
        check_idle_outputs("reset");

        // pclk: low two cycles, high two cycles
        areset = 1'b0;
        tick(1);
        check("pclk_c1", dvp_pclk, 0);
        tick(1);
        check("pclk_c2", dvp_pclk, 1);
        tick(2);
        check("pclk_c4", dvp_pclk, 0);

        // enable low blocks the frame start
        s_axis_tdata  = pix(0, 0, 0);
        s_axis_tuser  = 1'b1;
        s_axis_tvalid = 1'b1;
        tick(20);
        check("en_block_tready", s_axis_tready, 0);
        check("en_block_vsync", dvp_vsync, 0);

        // normal frame
        snap();
        enable = 1'b1;
        send_frame(0, W * H, -1, -1);
        wait_frame("t1");
        check_frame("t1", 0, -1);
        check("t1_px1_hi", (b0 + 2 < bytes_q.size()) ? bytes_q[b0 + 2] : 8'hxx, 8'h10);
        check("t1_px1_lo", (b0 + 3 < bytes_q.size()) ? bytes_q[b0 + 3] : 8'hxx, 8'h00);
        check("t1_latency", (lat_q.size() > l0) ? lat_q[l0] : -1, (VS + VB) * DIV);
        check("t1_vsync_w", (vsw_q.size() > v0) ? vsw_q[v0] : -1, VS);
        check("t1_sync_err", se_cnt - e0, 0);
        check("t1_underrun", underrun, 0);

        // two stray beats before SOF are discarded
        snap();
        send_beat(32'h1234_5678, 1'b0, 1'b0);
        send_beat(32'h9ABC_DEF0, 1'b0, 1'b1);
        tick(4);
        check("t2_discard_err", se_cnt - e0, 2);
        send_frame(1, W * H, -1, -1);
        wait_frame("t2");
        check_frame("t2", 1, -1);
        check("t2_sync_err", se_cnt - e0, 2);

        // missing tlast at column 7 of line 1
        snap();
        send_frame(0, W * H, -1, W + W - 1);
        wait_frame("t3");
        check_frame("t3", 0, -1);
        check("t3_sync_err", se_cnt - e0, 1);

        // source stall in line 2 gives one black pixel
        snap();
        check("t4_underrun_pre", underrun, 0);
        send_frame(1, W * H, 2 * W + 3, -1);
        wait_frame("t4");
        check_frame("t4", 1, 2 * W + 3);
        check("t4_zero_hi", (b0 + 38 < bytes_q.size()) ? bytes_q[b0 + 38] : 8'hxx, 8'h00);
        check("t4_zero_lo", (b0 + 39 < bytes_q.size()) ? bytes_q[b0 + 39] : 8'hxx, 8'h00);
        check("t4_underrun", underrun, 1);
        check("t4_sync_err", se_cnt - e0, 0);

        // reset during line 2, then a clean frame
        snap();
        send_frame(0, 20, -1, -1);
        k = 0;
        while (href_rises < h0 + 3 && k < 4000) begin
            tick(1);
            k++;
        end
        check("t5_in_line2", href_rises - h0, 3);
        tick(8);
        check("t5_href_before", dvp_href, 1);
        areset = 1'b1;
        tick(1);
        check_idle_outputs("t5_rst");
        areset = 1'b0;
        tick(4);
        snap();
        send_frame(1, W * H, -1, -1);
        wait_frame("t5");
        check_frame("t5", 1, -1);
        check("t5_sync_err", se_cnt - e0, 0);
        check("t5_underrun", underrun, 0);

        check("accept_timeouts", timeouts, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
